// File: rtl/master_spi4post.sv
// Mode-0 SPI master for the Post machine loader: one 16-bit frame per write, command plus read-out frame per read.
// done pulses 33*HALF_DIV+CS_GAP cycles after the first CS fall (doubled for reads); start is ignored while busy.
module master_spi4post #(
  parameter int HALF_DIV = 4,
  parameter int CS_GAP   = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       op_read,
  input  logic       sel_ram,
  input  logic [7:0] addr,
  input  logic [3:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [3:0] rdata,
  output logic       resp_ok,
  output logic       CS,
  output logic       SCK,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    IDLE, SHIFT_LO, SHIFT_HI, CS_HOLD, GAP, DONE
  } state_t;

  localparam logic [7:0] HALF_LAST = 8'(HALF_DIV - 1);
  localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic        frm_q, frm_d;
  logic [15:0] word_q, word_d;
  logic [15:0] rx_q, rx_d;
  logic        cs_q, cs_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  rdata_q, rdata_d;
  logic        ok_q, ok_d;
  logic [3:0]  low_nib;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      frm_q   <= 1'b0;
      word_q  <= '0;
      rx_q    <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      frm_q   <= frm_d;
      word_q  <= word_d;
      rx_q    <= rx_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      ok_q    <= ok_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q + 8'd1;
    bit_d   = bit_q;
    frm_d   = frm_q;
    word_d  = word_q;
    rx_d    = rx_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    ok_d    = ok_q;
    if (op_read)      low_nib = 4'b0000;
    else if (sel_ram) low_nib = {3'b000, wdata[0]};
    else              low_nib = wdata;

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (start) begin
          word_d  = {op_read, sel_ram, 2'b00, addr, low_nib};
          frm_d   = 1'b0;
          bit_d   = '0;
          cs_d    = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = op_read;
          busy_d  = 1'b1;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_q == HALF_LAST) begin
          div_d   = '0;
          sck_d   = 1'b1;
          state_d = SHIFT_HI;
          if (frm_q) rx_d = {rx_q[14:0], MISO};
        end
      end
      SHIFT_HI: begin
        if (div_q == HALF_LAST) begin
          div_d = '0;
          sck_d = 1'b0;
          if (bit_q == 4'd15) begin
            bit_d   = '0;
            mosi_d  = 1'b0;
            state_d = CS_HOLD;
          end else begin
            bit_d   = bit_q + 4'd1;
            // Read-out frame sends zeros; command frame sends the next bit MSB first.
            mosi_d  = frm_q ? 1'b0 : word_q[4'd14 - bit_q];
            state_d = SHIFT_LO;
          end
        end
      end
      CS_HOLD: begin
        if (div_q == HALF_LAST) begin
          div_d   = '0;
          cs_d    = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (div_q == GAP_LAST) begin
          div_d = '0;
          if (word_q[15] && !frm_q) begin
            frm_d   = 1'b1;
            cs_d    = 1'b0;
            mosi_d  = 1'b0;
            state_d = SHIFT_LO;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
            if (word_q[15]) begin
              rdata_d = rx_q[3:0];
              ok_d    = (rx_q[15:4] == word_q[15:4]);
            end
          end
        end
      end
      DONE: begin
        div_d   = '0;
        state_d = IDLE;
      end
      default: begin
        div_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign resp_ok = ok_q;
  assign CS      = cs_q;
  assign SCK     = sck_q;
  assign MOSI    = mosi_q;

endmodule

// File: tb/tb_master_spi4post.sv
// Bench for master_spi4post: behavioural SPI slave with its own memories, plus a scoreboard of frames and results.
module tb_master_spi4post;
  localparam int HD = 4;
  localparam int CG = 4;
  localparam int FRAME_LEN = 33 * HD + CG;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic       op_read;
  logic       sel_ram;
  logic [7:0] addr;
  logic [3:0] wdata;
  logic       busy, done, resp_ok, CS, SCK, MOSI;
  logic [3:0] rdata;
  logic       MISO = 1'b0;

  master_spi4post #(.HALF_DIV(HD), .CS_GAP(CG)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op_read(op_read), .sel_ram(sel_ram),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .resp_ok(resp_ok), .CS(CS), .SCK(SCK), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model and scoreboard queues
  typedef struct {
    logic [3:0] rd;
    logic       ok;
    int         lat;
  } exp_t;

  logic [3:0]  m_rom [256];
  logic        m_ram [256];
  logic [3:0]  last_rd = 4'h0;
  logic        last_ok = 1'b0;
  logic [15:0] exp_frames [$];
  exp_t        exp_q [$];
  logic        corrupt_f = 1'b0;

  // Behavioural slave
  logic [3:0]  s_rom [256];
  logic        s_ram [256];
  logic        p_cs = 1'b1, p_sck = 1'b0;
  int          nbits = 0;
  logic [15:0] sh = '0, tx = '0, ef;
  logic        pend = 1'b0;
  logic [15:0] pend_hdr = '0;
  logic [3:0]  pdata = '0;
  int          upd = 0;
  int          txi = 0;

  always @(negedge CLK) begin
    if (p_cs && !CS) begin
      nbits = 0;
      sh    = '0;
      upd   = 0;
      if (pend) begin
        tx = {pend_hdr[15:4], pdata};
        if (corrupt_f) tx[10] = ~tx[10];
        txi  = 15;
        MISO = tx[15];
      end
    end
    if (!CS && !p_sck && SCK) begin
      sh = {sh[14:0], MOSI};
      nbits++;
    end
    if (!CS && p_sck && !SCK) begin
      upd = 2;
    end else if (upd > 0) begin
      upd--;
      if (upd == 0 && pend && txi > 0) begin
        txi--;
        MISO = tx[txi];
      end
    end
    if (!p_cs && CS) begin
      if (nbits == 16) begin
        if (exp_frames.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame: got %0h, expected none", sh);
        end else begin
          ef = exp_frames.pop_front();
          check(pend ? "readout_frame_mosi" : "frame_word", 32'(sh), 32'(ef));
        end
        if (pend) begin
          pend = 1'b0;
        end else if (sh[15]) begin
          pend     = 1'b1;
          pend_hdr = sh;
          pdata    = sh[14] ? {3'b000, s_ram[sh[11:4]]} : s_rom[sh[11:4]];
        end else if (sh[14]) begin
          s_ram[sh[11:4]] = sh[0];
        end else begin
          s_rom[sh[11:4]] = sh[3:0];
        end
      end else begin
        pend = 1'b0;
      end
      nbits = 0;
    end
    p_cs  = CS;
    p_sck = SCK;
  end

  // Result monitor
  logic p_busy = 1'b0;
  int   t0 = 0;
  int   done_cnt = 0;
  exp_t em;

  always @(negedge CLK) begin
    if (busy && !p_busy) t0 = cyc;
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1, expected no transaction");
      end else begin
        em = exp_q.pop_front();
        check("done_latency", 32'(cyc - t0), 32'(em.lat));
        check("rdata", 32'(rdata), 32'(em.rd));
        check("resp_ok", 32'(resp_ok), 32'(em.ok));
        check("busy_at_done", 32'(busy), 32'(0));
      end
    end
    p_busy = busy;
  end

  task automatic push_exp(input logic op, input logic ram, input logic [7:0] a,
                          input logic [3:0] wd, input logic cor);
    logic [3:0] low;
    exp_t e;
    low = op ? 4'h0 : (ram ? {3'b000, wd[0]} : wd);
    exp_frames.push_back({op, ram, 2'b00, a, low});
    if (op) begin
      exp_frames.push_back(16'h0000);
      last_rd = ram ? {3'b000, m_ram[a]} : m_rom[a];
      last_ok = !cor;
      e.lat   = 2 * FRAME_LEN;
    end else begin
      if (ram) m_ram[a] = wd[0];
      else     m_rom[a] = wd;
      e.lat = FRAME_LEN;
    end
    e.rd = last_rd;
    e.ok = last_ok;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic op, input logic ram, input logic [7:0] a, input logic [3:0] wd);
    @(posedge CLK);
    #1;
    op_read = op;
    sel_ram = ram;
    addr    = a;
    wdata   = wd;
    start   = 1'b1;
    @(posedge CLK);
    #1;
    start   = 1'b0;
    op_read = 1'($urandom);
    sel_ram = 1'($urandom);
    addr    = 8'($urandom);
    wdata   = 4'($urandom);
  endtask

  task automatic wait_done(input int n0);
    int k;
    k = 0;
    while (done_cnt == n0 && k < 2000) begin
      @(posedge CLK);
      k++;
    end
    if (done_cnt == n0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", k);
    end
    @(posedge CLK);
  endtask

  task automatic txn(input logic op, input logic ram, input logic [7:0] a,
                     input logic [3:0] wd, input logic cor);
    int n0;
    n0 = done_cnt;
    corrupt_f = cor;
    push_exp(op, ram, a, wd, cor);
    issue(op, ram, a, wd);
    wait_done(n0);
    corrupt_f = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int k;
    logic op, ram, cor;
    logic [7:0] a;
    logic [3:0] wd, v;

    RST = 1'b1; start = 1'b0; op_read = 1'b0; sel_ram = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < 256; i++) begin
      v = 4'($urandom);
      m_rom[i] = v;
      s_rom[i] = v;
      m_ram[i] = v[0];
      s_ram[i] = v[0];
    end
    m_rom[255] = 4'h7;
    s_rom[255] = 4'h7;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_CS", 32'(CS), 32'(1));
    check("rst_SCK", 32'(SCK), 32'(0));
    check("rst_MOSI", 32'(MOSI), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(0));
    check("rst_resp_ok", 32'(resp_ok), 32'(0));
    RST = 1'b0;
    repeat (2) @(posedge CLK);

    txn(1'b0, 1'b0, 8'h5A, 4'hC, 1'b0);
    txn(1'b0, 1'b1, 8'h03, 4'h1, 1'b0);
    txn(1'b1, 1'b1, 8'h03, 4'h0, 1'b0);
    txn(1'b1, 1'b0, 8'hFF, 4'h0, 1'b0);
    txn(1'b1, 1'b0, 8'h5A, 4'h0, 1'b1);

    // start while busy must be ignored
    n0 = done_cnt;
    push_exp(1'b0, 1'b0, 8'h21, 4'h9, 1'b0);
    issue(1'b0, 1'b0, 8'h21, 4'h9);
    repeat (48) @(posedge CLK);
    #1;
    op_read = 1'b0; sel_ram = 1'b0; addr = 8'h77; wdata = 4'h3; start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    wait_done(n0);
    txn(1'b1, 1'b0, 8'h21, 4'h0, 1'b0);
    txn(1'b1, 1'b0, 8'h77, 4'h0, 1'b0);

    // asynchronous reset in the middle of frame 1
    n0 = done_cnt;
    issue(1'b0, 1'b0, 8'h40, 4'h5);
    k = 0;
    while (nbits != 7 && k < 500) begin
      @(posedge CLK);
      k++;
    end
    check("abort_reached_bit7", 32'(nbits), 32'(7));
    #2;
    RST = 1'b1;
    #1;
    check("abort_CS", 32'(CS), 32'(1));
    check("abort_SCK", 32'(SCK), 32'(0));
    check("abort_MOSI", 32'(MOSI), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    last_rd = 4'h0;
    last_ok = 1'b0;
    repeat (300) @(posedge CLK);
    check("abort_no_done", 32'(done_cnt), 32'(n0));
    txn(1'b0, 1'b0, 8'h40, 4'h5, 1'b0);
    txn(1'b1, 1'b0, 8'h40, 4'h0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      op  = 1'($urandom);
      ram = 1'($urandom);
      a   = 8'($urandom);
      wd  = 4'($urandom);
      cor = op && ($urandom_range(0, 3) == 0);
      txn(op, ram, a, wd, cor);
    end

    repeat (5) @(posedge CLK);
    check("frames_consumed", 32'(exp_frames.size()), 32'(0));
    check("results_consumed", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
